// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register that feeds decode.
// Holds the fetch PC, drives a word-addressed combinational instruction
// memory and latches {instruction, pc+1, valid} for the decode stage. Fetches
// one instruction per cycle unless stalled, redirected or halted.
//
// Ports
//   clk               in   1     rising-edge clock
//   rst_n             in   1     asynchronous active-low reset
//   imem_addr         out  PC_W  instruction memory address (equals pc)
//   imem_data         in   16    instruction at imem_addr, same cycle
//   stall             in   1     hold PC and IF/ID (load-use hazard)
//   redirect          in   1     taken branch/jump resolved downstream
//   redirect_target   in   PC_W  next fetch address when redirect is high
//   pc                out  PC_W  current fetch PC
//   if_id_instruction out  16    instruction presented to decode
//   if_id_pc_plus1    out  PC_W  fetch PC + 1 of that instruction
//   if_id_valid       out  1     if_id_instruction is a real instruction
//   halted            out  1     fetch FSM is in the halted state
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned    PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [15:0]    NOP_INSTR   = 16'h0000,
    parameter logic [2:0]     HALT_OPCODE = 3'b111
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     if_id_instruction,
    output logic [PC_W-1:0] if_id_pc_plus1,
    output logic            if_id_valid,
    output logic            halted
);

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_plus1_q, pc_plus1_d;
    logic            valid_q, valid_d;

    logic [PC_W-1:0] pc_inc;
    logic            is_halt;

    // Wraps modulo 2^PC_W by construction of the width.
    assign pc_inc  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign is_halt = (imem_data[15:13] == HALT_OPCODE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;

        unique case (state_q)
            // Nothing can be in flight yet, so redirect and stall are ignored.
            StBoot: begin
                state_d = StRun;
            end

            StRun: begin
                if (redirect) begin
                    // Branch is older than any hazard: it wins over stall.
                    pc_d    = redirect_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d    = imem_data;
                    pc_plus1_d = pc_inc;
                    valid_d    = 1'b1;
                    if (is_halt) begin
                        // Halt is handed to decode once; PC parks on it.
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end

            StHalted: begin
                if (redirect) begin
                    // An older branch made the halt wrong-path: resume.
                    pc_d    = redirect_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StRun;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr         = pc_q;
    assign pc                = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus1    = pc_plus1_q;
    assign if_id_valid       = valid_q;
    assign halted            = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Instruction memory is modelled as
// imem[k] = 16'h1000 + k, with address 5 optionally replaced by a halt word.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic [15:0] pc;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;

    logic        halt_en;
    int          tests;
    int          fails;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus1    (if_id_pc_plus1),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
    );

    always_comb begin
        if (halt_en && imem_addr == 16'h0005) imem_data = 16'hE000;
        else                                  imem_data = 16'h1000 + imem_addr;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc1,
                            input logic vld, input logic [15:0] pcv, input logic hlt);
        chk({tag, ".instr"}, {16'h0, if_id_instruction}, {16'h0, ins});
        chk({tag, ".pc1"},   {16'h0, if_id_pc_plus1},    {16'h0, pc1});
        chk({tag, ".valid"}, {31'h0, if_id_valid},       {31'h0, vld});
        chk({tag, ".pc"},    {16'h0, pc},                {16'h0, pcv});
        chk({tag, ".halted"}, {31'h0, halted},           {31'h0, hlt});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tests           = 0;
        fails           = 0;
        halt_en         = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        rst_n           = 1'b0;

        // Reset values
        #2;
        chk_ifid("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk("reset.imem_addr", {16'h0, imem_addr}, 32'h0);
        #5 rst_n = 1'b1;

        // 1: boot bubble, then sequential fetch
        tick();
        chk_ifid("boot", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tick();
        chk_ifid("seq0", 16'h1000, 16'h0001, 1'b1, 16'h0001, 1'b0);
        chk("seq0.imem_addr", {16'h0, imem_addr}, 32'h1);
        tick();
        chk_ifid("seq1", 16'h1001, 16'h0002, 1'b1, 16'h0002, 1'b0);
        tick();
        chk_ifid("seq2", 16'h1002, 16'h0003, 1'b1, 16'h0003, 1'b0);

        // 2: two-cycle stall at pc=3
        stall = 1'b1;
        tick();
        chk_ifid("stall0", 16'h1002, 16'h0003, 1'b1, 16'h0003, 1'b0);
        tick();
        chk_ifid("stall1", 16'h1002, 16'h0003, 1'b1, 16'h0003, 1'b0);
        stall = 1'b0;
        tick();
        chk_ifid("resume", 16'h1003, 16'h0004, 1'b1, 16'h0004, 1'b0);

        // 3: redirect beats a simultaneous stall
        stall           = 1'b1;
        redirect        = 1'b1;
        redirect_target = 16'h0020;
        tick();
        chk_ifid("redir", 16'h0000, 16'h0004, 1'b0, 16'h0020, 1'b0);
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        chk_ifid("redir_fetch", 16'h1020, 16'h0021, 1'b1, 16'h0021, 1'b0);

        // 4: halt opcode at address 5
        halt_en         = 1'b1;
        redirect        = 1'b1;
        redirect_target = 16'h0003;
        tick();
        redirect = 1'b0;
        chk_ifid("to3", 16'h0000, 16'h0021, 1'b0, 16'h0003, 1'b0);
        tick();
        chk_ifid("f3", 16'h1003, 16'h0004, 1'b1, 16'h0004, 1'b0);
        tick();
        chk_ifid("f4", 16'h1004, 16'h0005, 1'b1, 16'h0005, 1'b0);
        tick();
        chk_ifid("halt_in", 16'hE000, 16'h0006, 1'b1, 16'h0005, 1'b1);
        tick();
        chk_ifid("halt_b0", 16'h0000, 16'h0006, 1'b0, 16'h0005, 1'b1);
        tick();
        chk_ifid("halt_b1", 16'h0000, 16'h0006, 1'b0, 16'h0005, 1'b1);
        stall = 1'b1;
        tick();
        chk_ifid("halt_stall", 16'h0000, 16'h0006, 1'b0, 16'h0005, 1'b1);
        stall           = 1'b0;
        redirect        = 1'b1;
        redirect_target = 16'h0008;
        tick();
        redirect = 1'b0;
        chk_ifid("unhalt", 16'h0000, 16'h0006, 1'b0, 16'h0008, 1'b0);
        halt_en = 1'b0;
        tick();
        chk_ifid("unhalt_f", 16'h1008, 16'h0009, 1'b1, 16'h0009, 1'b0);

        // 5: PC wrap at 0xFFFF
        redirect        = 1'b1;
        redirect_target = 16'hFFFF;
        tick();
        redirect = 1'b0;
        chk_ifid("to_ffff", 16'h0000, 16'h0009, 1'b0, 16'hFFFF, 1'b0);
        tick();
        chk_ifid("wrap", 16'h0FFF, 16'h0000, 1'b1, 16'h0000, 1'b0);

        // 6: asynchronous reset mid-stream, redirect ignored during boot
        tick();
        halt_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_ifid("async_rst", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        #3 rst_n = 1'b1;
        redirect        = 1'b1;
        redirect_target = 16'h0040;
        halt_en         = 1'b0;
        tick();
        redirect = 1'b0;
        chk_ifid("boot2", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tick();
        chk_ifid("boot2_f", 16'h1000, 16'h0001, 1'b1, 16'h0001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
